lsu_dbus_ctrl: RTL and testbench
================================

Name: lsu_dbus_ctrl

Overview:
- Load/store bus controller in the MEM stage; sits directly upstream of the load-data extension stage.
- Accepts one memory request at a time from the pipeline and drives a word-addressed SRAM-like data bus with a two-phase handshake (addr_ok, then data_ok).
- Aligns store data and byte strobes; captures raw load data plus the byte offset and extension op for the extension stage.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, address width; bus address is word-aligned, with bits [1:0] forced to 0.

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents a memory op
- req_ready  out  1  controller can accept (IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word (11 treated as word)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- req_ext_op  in  3  load extension op, carried through unchanged
- flush  in  1  cancel the in-flight/presented op (exception/branch)
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write
- dbus_addr  out  ADDR_W  word-aligned address
- dbus_wstrb  out  4  byte strobes (0000 for loads)
- dbus_wdata  out  32  lane-replicated store data
- dbus_addr_ok  in  1  bus accepted address phase
- dbus_data_ok  in  1  bus completed data phase
- dbus_rdata  in  32  raw read word
- ld_valid  out  1  one-cycle pulse: load response ready
- ld_data  out  32  registered raw word for the extension stage
- ld_byte_offset  out  2  latched addr[1:0]
- ld_ext_op  out  3  latched req_ext_op
- st_done  out  1  one-cycle pulse: store completed
- busy  out  1  stall to pipeline
- ale  out  1  one-cycle pulse: misaligned access (optional feature)
- ale_badv  out  ADDR_W  faulting address (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; cancel flag 0.
- Accept: req_ready = (state==IDLE). A request is accepted when req_valid & req_ready & !flush; it is then latched in full, and the latched copy drives the dbus_* outputs. With flush in IDLE, the presented op is dropped.
- busy = (state!=IDLE) | (req_valid & state==IDLE & !flush).
- States:
  - IDLE: on accept, go to REQ.
  - REQ: dbus_req=1, held with stable dbus_* until dbus_addr_ok. On addr_ok & data_ok in the same cycle, go to IDLE and complete. On addr_ok alone, go to WAIT.
  - WAIT: dbus_req=0. On data_ok, go to IDLE and complete.
- Complete:
  - Load: ld_data <= dbus_rdata; ld_valid=1 next cycle.
  - Store: st_done=1 next cycle.
  - Both pulses are suppressed if the cancel flag is set.
  - ld_data, ld_byte_offset and ld_ext_op hold until the next load completion.
- Minimum latency: accept at cycle N, bus request at N+1, addr_ok+data_ok at N+1, response pulse at N+2.
- flush in REQ or WAIT: the bus transaction still runs to completion (dbus_req is never dropped before addr_ok), and the cancel flag is set so the response is suppressed. The cancel flag clears on return to IDLE.
- Store lanes:
  - Byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - Word: wdata passed through, wstrb = 1111.
- Load: wstrb = 0000; dbus_wdata is don't-care and driven 0.
- Reset asserted mid-transaction: return to IDLE immediately and drop dbus_req. A late data_ok in IDLE is ignored.

Optional Feature:
- LSU_ALE_CHECK_EN defined:
  - Misalignment is half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned accepted request issues no bus transaction; it pulses ale and loads ale_badv=req_addr in the accept cycle.
  - State stays IDLE and no ld_valid/st_done is produced.
  - flush has priority over ale.
- Not defined: ale and ale_badv are tied to 0. Misaligned addresses proceed using addr[1:0] as given for strobes and offset.

Decomposition:
- defines.vh gets:
  - size codes MEM_SIZE_B/H/W;
  - state encodings LSU_IDLE/REQ/WAIT.
- The extension op codes already live there and are carried through opaquely.
- One sub-module, lsu_store_align: combinational (size, offset, wdata) -> (wstrb, lane data).

Test Plan:
- Load word: addr=0x1000_0008, addr_ok at +1, data_ok at +3, rdata=0xDEAD_BEEF -> dbus_addr=0x1000_0008, wstrb=0000, ld_valid pulse once, ld_data=0xDEAD_BEEF, ld_byte_offset=00, busy high for 4 cycles.
- Store byte: addr=0x...3, wdata=0x0000_00A5 -> wstrb=1000, dbus_wdata=0xA5A5_A5A5, dbus_addr low bits 00, st_done once.
- Store half: addr=0x...2, wdata=0x1234 -> wstrb=1100, dbus_wdata=0x1234_1234. Zero-wait bus (addr_ok & data_ok in the same cycle) -> st_done at accept+2.
- Load byte: addr=0x...1, req_ext_op=3'b101 -> ld_byte_offset=01, ld_ext_op=101. Hold addr_ok low for 5 cycles -> dbus_req stays high with stable addr.
- Flush in WAIT -> data_ok still consumed, no ld_valid, req_ready returns next cycle. Flush in IDLE with req_valid -> no dbus_req.
- With LSU_ALE_CHECK_EN: word load at 0x...6 -> ale=1, ale_badv=0x...6, dbus_req never asserted. Without the macro -> normal access, ld_byte_offset=10.

Source files
------------

// File: rtl/lsu_dbus_ctrl_pkg.sv
// lsu_dbus_ctrl_pkg: size codes, controller state encoding and alignment helper
package lsu_dbus_ctrl_pkg;
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT} lsu_state_e;

    // size code 11 counts as a word access
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == MEM_SIZE_H) & off[0]) | ((size == MEM_SIZE_W | size == 2'b11) & (off != 2'b00));
    endfunction
endpackage

// File: rtl/lsu_dbus_ctrl_store_align.sv
// lsu_store_align: byte strobes and lane-replicated store data from size/offset
module lsu_store_align
    import lsu_dbus_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_data
);
    always_comb begin
        wstrb     = (size == MEM_SIZE_B) ? 4'b0001 << offset :
                    (size == MEM_SIZE_H) ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        lane_data = (size == MEM_SIZE_B) ? {4{wdata[7:0]}} :
                    (size == MEM_SIZE_H) ? {2{wdata[15:0]}} : wdata;
    end
endmodule

// File: rtl/lsu_dbus_ctrl.sv
// lsu_dbus_ctrl: MEM-stage load/store controller for a two-phase (addr_ok/data_ok) bus.
// Define LSU_ALE_CHECK_EN to trap misaligned half/word accesses via ale/ale_badv.
module lsu_dbus_ctrl
    import lsu_dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_ext_op,
    input  logic              flush,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_addr_ok,
    input  logic              dbus_data_ok,
    input  logic [31:0]       dbus_rdata,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [1:0]        ld_byte_offset,
    output logic [2:0]        ld_ext_op,
    output logic              st_done,
    output logic              busy,
    output logic              ale,
    output logic [ADDR_W-1:0] ale_badv
);
    lsu_state_e        state_q, state_d;
    logic              we_q, cancel_q, cancel_d, ld_valid_q, ld_valid_d, st_done_q, st_done_d;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, ld_data_q, ld_data_d;
    logic [2:0]        ext_q, ext_d, ld_ext_q, ld_ext_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic              accept, go, done, ale_d;
    logic [ADDR_W-1:0] ale_badv_d;
    logic [3:0]        strb;
    logic [31:0]       lane;

    lsu_store_align u_align (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .wstrb     (strb),
        .lane_data (lane)
    );

    always_comb begin
        accept     = req_valid & (state_q == LSU_IDLE) & ~flush;
`ifdef LSU_ALE_CHECK_EN
        ale_d      = accept & misaligned(req_size, req_addr[1:0]);
        ale_badv_d = ale_d ? req_addr : ale_badv;
`else
        ale_d      = 1'b0;
        ale_badv_d = '0;
`endif
        go         = accept & ~ale_d;
        done       = ((state_q == LSU_REQ) & dbus_addr_ok & dbus_data_ok) | ((state_q == LSU_WAIT) & dbus_data_ok);
        state_d    = (state_q == LSU_IDLE) ? (go ? LSU_REQ : LSU_IDLE) :
                     (state_q == LSU_REQ)  ? (dbus_addr_ok ? (dbus_data_ok ? LSU_IDLE : LSU_WAIT) : LSU_REQ) :
                     (dbus_data_ok ? LSU_IDLE : LSU_WAIT);
        // a flush landing on the completing cycle also kills that response
        cancel_d   = (state_d != LSU_IDLE) & (cancel_q | flush);
        ld_valid_d = done & ~we_q & ~(cancel_q | flush);
        st_done_d  = done & we_q & ~(cancel_q | flush);
        addr_d     = go ? req_addr : addr_q;
        wdata_d    = go ? req_wdata : wdata_q;
        ext_d      = go ? req_ext_op : ext_q;
        ld_data_d  = ld_valid_d ? dbus_rdata : ld_data_q;
        ld_off_d   = ld_valid_d ? addr_q[1:0] : ld_off_q;
        ld_ext_d   = ld_valid_d ? ext_q : ld_ext_q;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q    <= LSU_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            ext_q      <= '0;
            cancel_q   <= 1'b0;
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            ld_data_q  <= '0;
            ld_off_q   <= '0;
            ld_ext_q   <= '0;
            ale        <= 1'b0;
            ale_badv   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= go ? req_we : we_q;
            size_q     <= go ? req_size : size_q;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ext_q      <= ext_d;
            cancel_q   <= cancel_d;
            ld_valid_q <= ld_valid_d;
            st_done_q  <= st_done_d;
            ld_data_q  <= ld_data_d;
            ld_off_q   <= ld_off_d;
            ld_ext_q   <= ld_ext_d;
            ale        <= ale_d;
            ale_badv   <= ale_badv_d;
        end
    end

    assign req_ready      = (state_q == LSU_IDLE);
    assign busy           = (state_q != LSU_IDLE) | accept;
    assign dbus_req       = (state_q == LSU_REQ);
    assign dbus_we        = we_q;
    assign dbus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign dbus_wstrb     = we_q ? strb : 4'b0000;
    assign dbus_wdata     = we_q ? lane : 32'h0;
    assign ld_valid       = ld_valid_q;
    assign st_done        = st_done_q;
    assign ld_data        = ld_data_q;
    assign ld_byte_offset = ld_off_q;
    assign ld_ext_op      = ld_ext_q;
endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// tb_lsu_dbus_ctrl: directed plus randomized transactions against a transaction-level model
module tb_lsu_dbus_ctrl;
    logic        cpu_clk = 1'b0, cpu_rst = 1'b1;
    logic        req_valid = 0, req_ready, req_we = 0, flush = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_ext_op = 0;
    logic        dbus_req, dbus_we, dbus_addr_ok = 0, dbus_data_ok = 0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = 0, ld_data, ale_badv;
    logic [3:0]  dbus_wstrb;
    logic        ld_valid, st_done, busy, ale;
    logic [1:0]  ld_byte_offset;
    logic [2:0]  ld_ext_op;
    int          checks = 0, errors = 0;
    logic [31:0] m_ld_data = 0;
    logic [1:0]  m_ld_off = 0;
    logic [2:0]  m_ld_ext = 0;

    lsu_dbus_ctrl #(.ADDR_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ext_op(req_ext_op), .flush(flush), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
        .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_byte_offset(ld_byte_offset),
        .ld_ext_op(ld_ext_op), .st_done(st_done), .busy(busy), .ale(ale), .ale_badv(ale_badv)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // al: REQ cycles before addr_ok; dl: cycles from addr_ok to data_ok; fl: flush cycle (-1 none)
    task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [2:0] eo, input int al, input int dl, input int fl);
        logic [31:0] ew, rd;
        logic [3:0]  es;
        logic [1:0]  off;
        logic        killed;
        int          n;
        off    = ad[1:0];
        n      = al + dl;
        killed = (fl >= 0) && (fl <= n);
        rd     = 0;
        if (!we) begin
            es = 4'h0; ew = 0;
        end else if (sz == 2'b00) begin
            es = 4'(1 << off); ew = {24'h0, wd[7:0]} * 32'h0101_0101;
        end else if (sz == 2'b01) begin
            es = 4'(3 << (off & 2'b10)); ew = {16'h0, wd[15:0]} * 32'h0001_0001;
        end else begin
            es = 4'hF; ew = wd;
        end
        @(negedge cpu_clk);
        req_valid = 1; req_we = we; req_size = sz; req_addr = ad; req_wdata = wd; req_ext_op = eo; flush = 0;
        #1;
        chk("busy_accept", {31'h0, busy}, 1);
        chk("ready_accept", {31'h0, req_ready}, 1);
        for (int c = 0; c <= n; c++) begin
            @(negedge cpu_clk);
            req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
            chk("dbus_req", {31'h0, dbus_req}, {31'h0, c <= al});
            chk("busy_txn", {31'h0, busy}, 1);
            chk("ready_txn", {31'h0, req_ready}, 0);
            if (c <= al) begin
                chk("dbus_addr", dbus_addr, {ad[31:2], 2'b00});
                chk("dbus_we", {31'h0, dbus_we}, {31'h0, we});
                chk("dbus_wstrb", {28'h0, dbus_wstrb}, {28'h0, es});
                chk("dbus_wdata", dbus_wdata, ew);
            end
            dbus_addr_ok = (c == al);
            dbus_data_ok = (c == n);
            dbus_rdata   = $urandom;
            flush        = (c == fl);
            if (c == n) rd = dbus_rdata;
        end
        @(negedge cpu_clk);
        dbus_addr_ok = 0; dbus_data_ok = 0; flush = 0;
        if (!we && !killed) begin
            m_ld_data = rd; m_ld_off = off; m_ld_ext = eo;
        end
        chk("ld_valid", {31'h0, ld_valid}, {31'h0, !we && !killed});
        chk("st_done", {31'h0, st_done}, {31'h0, we && !killed});
        chk("ready_after", {31'h0, req_ready}, 1);
        chk("busy_after", {31'h0, busy}, 0);
        chk("ld_data", ld_data, m_ld_data);
        chk("ld_off", {30'h0, ld_byte_offset}, {30'h0, m_ld_off});
        chk("ld_ext", {29'h0, ld_ext_op}, {29'h0, m_ld_ext});
        @(negedge cpu_clk);
        chk("ld_valid_pulse", {31'h0, ld_valid}, 0);
        chk("st_done_pulse", {31'h0, st_done}, 0);
    endtask

    initial begin
        #1;
        chk("rst_dbus_req", {31'h0, dbus_req}, 0);
        chk("rst_ready", {31'h0, req_ready}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 0);
        chk("rst_st_done", {31'h0, st_done}, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_wstrb", {28'h0, dbus_wstrb}, 0);
        chk("rst_ale", {31'h0, ale}, 0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 0;

        txn(0, 2'b10, 32'h1000_0008, 32'h0, 3'b000, 0, 2, -1);
        txn(1, 2'b00, 32'h2000_0003, 32'h0000_00A5, 3'b000, 1, 1, -1);
        txn(1, 2'b01, 32'h2000_0002, 32'h0000_1234, 3'b000, 0, 0, -1);
        txn(0, 2'b00, 32'h3000_0001, 32'h0, 3'b101, 5, 0, -1);
        txn(0, 2'b10, 32'h4000_0010, 32'h0, 3'b010, 0, 2, 1);
        txn(0, 2'b10, 32'h5000_0006, 32'h0, 3'b011, 0, 1, -1);
        txn(1, 2'b11, 32'h6000_0004, 32'hCAFE_F00D, 3'b000, 2, 0, 0);

        @(negedge cpu_clk);
        req_valid = 1; req_we = 0; req_addr = 32'h7000_0000; flush = 1;
        #1;
        chk("flush_idle_busy", {31'h0, busy}, 0);
        @(negedge cpu_clk);
        req_valid = 0; flush = 0;
        chk("flush_idle_req", {31'h0, dbus_req}, 0);
        chk("flush_idle_ready", {31'h0, req_ready}, 1);

        @(negedge cpu_clk);
        req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h7000_0100;
        @(negedge cpu_clk);
        req_valid = 0;
        chk("rst_mid_req", {31'h0, dbus_req}, 1);
        cpu_rst = 1;
        #1;
        chk("rst_mid_drop", {31'h0, dbus_req}, 0);
        chk("rst_mid_busy", {31'h0, busy}, 0);
        m_ld_data = 0; m_ld_off = 0; m_ld_ext = 0;
        @(negedge cpu_clk);
        cpu_rst = 0; dbus_data_ok = 1; dbus_rdata = 32'h1234_5678;
        @(negedge cpu_clk);
        dbus_data_ok = 0;
        chk("late_data_ok", {31'h0, ld_valid}, 0);
        chk("late_ld_data", ld_data, 0);
        chk("late_ready", {31'h0, req_ready}, 1);

        for (int i = 0; i < 300; i++) begin
            int al, dl, fl;
            al = $urandom_range(0, 4);
            dl = $urandom_range(0, 3);
            fl = ($urandom_range(0, 9) < 3) ? $urandom_range(0, al + dl + 1) : -1;
            txn(1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), al, dl, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
